// File: rtl/cwt_scale_readout_ctrl.sv
// cwt_scale_readout_ctrl: drains the CWT scale RAMs in scale/sample order to a valid/ready stream
module cwt_scale_readout_ctrl #(
  parameter int NUM_SCALES = 15,
  parameter int NUM_BANKS  = 32,
  parameter int BANK_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int SCALE_W    = 4,
  parameter int BANK_W     = 5,
  parameter int ADDR_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cwt_done,
  input  logic [DATA_W-1:0]  ram_rd_data,
  input  logic               out_ready,
  output logic               ram_rd_en,
  output logic [SCALE_W-1:0] scale_sel,
  output logic [BANK_W-1:0]  bank_sel,
  output logic [ADDR_W-1:0]  ram_rd_addr,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [SCALE_W-1:0] out_scale,
  output logic               out_last,
  output logic               busy,
  output logic               done
);
  localparam int N_W = BANK_W + ADDR_W;
  typedef enum logic [2:0] {IDLE, ISSUE, LATCH, PRESENT, FINISH} state_t;
  state_t state, next_state;
  logic [SCALE_W-1:0] scale;
  logic [N_W-1:0] n;
  logic last_n, last_scale, hs;
  assign last_n = n == N_W'(NUM_BANKS * BANK_DEPTH - 1);
  assign last_scale = scale == SCALE_W'(NUM_SCALES - 1);
  assign hs = state == PRESENT && out_ready;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = cwt_done ? ISSUE : IDLE;
      ISSUE:   next_state = LATCH;
      LATCH:   next_state = PRESENT;
      PRESENT: next_state = !out_ready ? PRESENT : (last_n && last_scale) ? FINISH : ISSUE;
      default: next_state = IDLE;
    endcase
    ram_rd_en   = state == ISSUE;
    out_valid   = state == PRESENT;
    done        = state == FINISH;
    busy        = state != IDLE;
    scale_sel   = scale;
    bank_sel    = n[BANK_W-1:0];
    ram_rd_addr = n[N_W-1:BANK_W];
  end
  always_ff @(posedge clk)
    if (rst) begin
      scale     <= '0;
      n         <= '0;
      out_data  <= '0;
      out_scale <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && cwt_done) begin
        scale <= '0;
        n     <= '0;
      end
      if (state == LATCH) begin
        out_data  <= ram_rd_data;
        out_scale <= scale;
        out_last  <= last_n;
      end
      if (hs && !(last_n && last_scale)) begin
        n <= last_n ? '0 : n + N_W'(1);
        if (last_n) scale <= scale + SCALE_W'(1);
      end
    end
endmodule

// File: tb/tb_cwt_scale_readout_ctrl.sv
// tb_cwt_scale_readout_ctrl: directed scenarios for the scale RAM readout controller
module tb_cwt_scale_readout_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cwt_done = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] ram_rd_data = '0;
  logic ram_rd_en, out_valid, out_last, busy, done;
  logic [3:0] scale_sel, out_scale;
  logic [4:0] bank_sel;
  logic [1:0] ram_rd_addr;
  logic [31:0] out_data;
  int total = 0;
  int bad = 0;

  cwt_scale_readout_ctrl dut (
    .clk(clk), .rst(rst), .cwt_done(cwt_done), .ram_rd_data(ram_rd_data), .out_ready(out_ready),
    .ram_rd_en(ram_rd_en), .scale_sel(scale_sel), .bank_sel(bank_sel), .ram_rd_addr(ram_rd_addr),
    .out_data(out_data), .out_valid(out_valid), .out_scale(out_scale), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM returns {scale,addr,bank}, which equals the global beat index of that sample
  always @(posedge clk)
    if (ram_rd_en) ram_rd_data <= {21'd0, scale_sel, ram_rd_addr, bank_sel};

  task automatic test_reset();
    int seen = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({ram_rd_en, scale_sel, bank_sel, ram_rd_addr, out_data, out_valid, out_scale, out_last, busy, done} !== 52'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {ram_rd_en, scale_sel, bank_sel, ram_rd_addr, out_data, out_valid, out_scale, out_last, busy, done});
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ram_rd_en || busy) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL idle_no_read active_cycles=%0d exp=0", seen);
    end
  endtask

  task automatic test_stream();
    int beat = 0, dones = 0, lasts = 0, issues = 0, cyc = 0;
    cwt_done = 1'b1;
    @(negedge clk);
    cwt_done = 1'b0;
    total++;
    if (!(ram_rd_en === 1'b1 && scale_sel === 4'd0 && bank_sel === 5'd0 && ram_rd_addr === 2'd0)) begin
      bad++;
      $display("FAIL first_issue en=%b s=%0d b=%0d a=%0d exp en=1 s=0 b=0 a=0", ram_rd_en, scale_sel, bank_sel, ram_rd_addr);
    end
    while (cyc < 5800) begin
      if (ram_rd_en) issues++;
      if (out_valid && out_ready) begin
        total++;
        if (cyc != 3 * beat + 2 || out_data !== 32'(beat) || out_scale !== 4'(beat / 128) || out_last !== (beat % 128 == 127)) begin
          bad++;
          $display("FAIL stream_beat%0d cyc=%0d data=%h scale=%0d last=%b exp cyc=%0d data=%h scale=%0d last=%b",
                   beat, cyc, out_data, out_scale, out_last, 3 * beat + 2, beat, beat / 128, beat % 128 == 127);
        end
        if (out_last) lasts++;
        beat++;
      end
      if (done) begin
        dones++;
        total++;
        if (cyc != 5760 || busy !== 1'b1) begin
          bad++;
          $display("FAIL done_timing cyc=%0d busy=%b exp cyc=5760 busy=1", cyc, busy);
        end
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (beat != 1920 || issues != 1920 || lasts != 15 || dones != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stream_totals beats=%0d issues=%0d lasts=%0d dones=%0d busy=%b exp 1920 1920 15 1 0", beat, issues, lasts, dones, busy);
    end
  endtask

  task automatic test_backpressure();
    int beat = 0, dones = 0, issues = 0, stall = 0, cyc = 0;
    bit wrap_chk = 1'b0;
    cwt_done = 1'b1;
    @(negedge clk);
    while (cyc < 6000) begin
      cwt_done = 1'b0;
      if (ram_rd_en) begin
        issues++;
        total++;
        if (scale_sel !== 4'(beat / 128) || bank_sel !== 5'(beat % 32) || ram_rd_addr !== 2'((beat % 128) / 32)) begin
          bad++;
          $display("FAIL issue_addr beat=%0d s=%0d b=%0d a=%0d exp s=%0d b=%0d a=%0d", beat, scale_sel, bank_sel, ram_rd_addr, beat / 128, beat % 32, (beat % 128) / 32);
        end
      end
      if (wrap_chk) begin
        wrap_chk = 1'b0;
        total++;
        if (!(ram_rd_en === 1'b1 && scale_sel === 4'd4 && bank_sel === 5'd0 && ram_rd_addr === 2'd0)) begin
          bad++;
          $display("FAIL wrap_issue en=%b s=%0d b=%0d a=%0d exp en=1 s=4 b=0 a=0", ram_rd_en, scale_sel, bank_sel, ram_rd_addr);
        end
      end
      if (out_valid && beat == 40 && stall < 10) begin
        out_ready = 1'b0;
        total++;
        if (out_data !== 32'd40 || out_scale !== 4'd0 || ram_rd_en !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold data=%h scale=%0d en=%b exp data=28 scale=0 en=0", out_data, out_scale, ram_rd_en);
        end
        stall++;
      end else out_ready = 1'b1;
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== 32'(beat) || out_scale !== 4'(beat / 128) || out_last !== (beat % 128 == 127)) begin
          bad++;
          $display("FAIL bp_beat%0d data=%h scale=%0d last=%b exp data=%h scale=%0d last=%b", beat, out_data, out_scale, out_last, beat, beat / 128, beat % 128 == 127);
        end
        if (beat == 40) begin
          total++;
          if (out_data !== 32'h0000_0028 || stall != 10) begin
            bad++;
            $display("FAIL resume_beat data=%h stall=%0d exp data=28 stall=10", out_data, stall);
          end
        end
        if (beat == 511) begin
          total++;
          if (out_last !== 1'b1 || out_scale !== 4'd3) begin
            bad++;
            $display("FAIL wrap_last last=%b scale=%0d exp last=1 scale=3", out_last, out_scale);
          end
          wrap_chk = 1'b1;
        end
        if (beat == 700) cwt_done = 1'b1;
        beat++;
      end
      if (done) begin
        dones++;
        cwt_done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    cwt_done = 1'b0;
    out_ready = 1'b1;
    total++;
    if (beat != 1920 || issues != 1920 || dones != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_totals beats=%0d issues=%0d dones=%0d busy=%b exp 1920 1920 1 0", beat, issues, dones, busy);
    end
  endtask

  task automatic test_abort_restart();
    int beat = 0, dones = 0, cyc = 0;
    cwt_done = 1'b1;
    @(negedge clk);
    cwt_done = 1'b0;
    while (cyc < 2000 && !(out_valid && beat == 500)) begin
      if (out_valid && out_ready) beat++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (beat != 500 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reach_beat500 beats=%0d valid=%b exp 500 1", beat, out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({ram_rd_en, scale_sel, bank_sel, ram_rd_addr, out_data, out_valid, out_scale, out_last, busy, done} !== 52'd0) begin
      bad++;
      $display("FAIL abort_outputs got=%h exp=0", {ram_rd_en, scale_sel, bank_sel, ram_rd_addr, out_data, out_valid, out_scale, out_last, busy, done});
    end
    repeat (3) @(negedge clk);
    cwt_done = 1'b1;
    @(negedge clk);
    cwt_done = 1'b0;
    total++;
    if (!(ram_rd_en === 1'b1 && scale_sel === 4'd0 && bank_sel === 5'd0 && ram_rd_addr === 2'd0)) begin
      bad++;
      $display("FAIL restart_issue en=%b s=%0d b=%0d a=%0d exp en=1 s=0 b=0 a=0", ram_rd_en, scale_sel, bank_sel, ram_rd_addr);
    end
    beat = 0;
    cyc = 0;
    while (cyc < 5800) begin
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== 32'(beat) || out_scale !== 4'(beat / 128) || out_last !== (beat % 128 == 127)) begin
          bad++;
          $display("FAIL restart_beat%0d data=%h scale=%0d last=%b exp data=%h scale=%0d last=%b", beat, out_data, out_scale, out_last, beat, beat / 128, beat % 128 == 127);
        end
        beat++;
      end
      if (done) dones++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (beat != 1920 || dones != 1) begin
      bad++;
      $display("FAIL restart_totals beats=%0d dones=%0d exp 1920 1", beat, dones);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
